// File: rtl/five_tuple_extract.sv
// five_tuple_extract: passive AXI4-Stream tap that pulls the IPv4 five-tuple
// out of each packet header and strobes it for one cycle.
`default_nettype none

module five_tuple_extract #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [103:0]                      five_tuple_data,
    output logic                              data_valid
);

    localparam logic [1:0] c_WAIT_B0 = 2'd0;
    localparam logic [1:0] c_WAIT_B1 = 2'd1;
    localparam logic [1:0] c_WAIT_B2 = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   r_beat_idx;
    logic [3:0]   r_ihl;
    logic [12:0]  r_frag;
    logic [7:0]   r_proto;
    logic [31:0]  r_src;
    logic [31:0]  r_dst;
    logic [15:0]  r_carry;
    logic [103:0] r_tuple;
    logic         r_valid;

    function automatic logic [7:0] f_byte(input logic [C_S_AXIS_DATA_WIDTH-1:0] d,
                                          input logic [4:0] n);
        return d[{n, 3'b000} +: 8];
    endfunction

    logic        w_beat;
    logic        w_hdr_ok;
    logic        w_l4;
    logic        w_near;
    logic [4:0]  w_off;
    logic [31:0] w_ports;
    logic [31:0] w_ports_b2;
    logic [31:0] w_dst_b1;
    logic        w_unused_ok;

    assign w_beat   = s_axis_tvalid & s_axis_tready;
    assign w_hdr_ok = ({f_byte(s_axis_tdata, 5'd12), f_byte(s_axis_tdata, 5'd13)} == 16'h0800)
                   && (f_byte(s_axis_tdata, 5'd14) >> 4 == 8'd4)
                   && (f_byte(s_axis_tdata, 5'd14) & 8'h0F) >= 8'd5;
    assign w_l4     = ((r_proto == 8'd6) || (r_proto == 8'd17)) && (r_frag == 13'd0);
    assign w_near   = (r_ihl <= 4'd11);

    // Port offset within the beat: 4*IHL+14 taken modulo 32. The same
    // formula lands on the right byte in beat1 (IHL<=11) and beat2 (IHL>=13).
    assign w_off    = {r_ihl[2:0], 2'b00} - 5'd18;
    assign w_ports  = {f_byte(s_axis_tdata, w_off),
                       f_byte(s_axis_tdata, w_off + 5'd1),
                       f_byte(s_axis_tdata, w_off + 5'd2),
                       f_byte(s_axis_tdata, w_off + 5'd3)};
    // IHL=12 places the source port in the last two bytes of beat1.
    assign w_ports_b2 = (r_ihl == 4'd12)
                      ? {r_carry, f_byte(s_axis_tdata, 5'd0), f_byte(s_axis_tdata, 5'd1)}
                      : w_ports;
    assign w_dst_b1 = {r_dst[31:16], f_byte(s_axis_tdata, 5'd0), f_byte(s_axis_tdata, 5'd1)};

    assign w_unused_ok = &{1'b0, s_axis_tkeep, s_axis_tuser, s_axis_tdata};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state    <= c_WAIT_B0;
            r_beat_idx <= 2'd0;
            r_ihl      <= 4'd0;
            r_frag     <= 13'd0;
            r_proto    <= 8'd0;
            r_src      <= 32'd0;
            r_dst      <= 32'd0;
            r_carry    <= 16'd0;
            r_tuple    <= 104'd0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_beat) begin
                r_beat_idx <= s_axis_tlast ? 2'd0
                            : (r_beat_idx == 2'd3) ? 2'd3 : r_beat_idx + 2'd1;
                case (r_state)
                    c_WAIT_B0: begin
                        r_ihl   <= s_axis_tdata[115:112];
                        r_frag  <= {s_axis_tdata[164:160], f_byte(s_axis_tdata, 5'd21)};
                        r_proto <= f_byte(s_axis_tdata, 5'd23);
                        r_src   <= {f_byte(s_axis_tdata, 5'd26), f_byte(s_axis_tdata, 5'd27),
                                    f_byte(s_axis_tdata, 5'd28), f_byte(s_axis_tdata, 5'd29)};
                        r_dst   <= {f_byte(s_axis_tdata, 5'd30), f_byte(s_axis_tdata, 5'd31), 16'd0};
                        if (s_axis_tlast || r_beat_idx != 2'd0) begin
                            r_state <= c_WAIT_B0;
                        end else if (!w_hdr_ok) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_state <= c_WAIT_B1;
                        end
                    end
                    c_WAIT_B1: begin
                        r_dst <= w_dst_b1;
                        if (!w_l4 || w_near) begin
                            r_tuple <= {r_src, w_dst_b1, w_l4 ? w_ports : 32'd0, r_proto};
                            r_valid <= 1'b1;
                            r_state <= s_axis_tlast ? c_WAIT_B0 : c_DRAIN;
                        end else if (s_axis_tlast) begin
                            r_state <= c_WAIT_B0;
                        end else begin
                            r_carry <= {f_byte(s_axis_tdata, 5'd30), f_byte(s_axis_tdata, 5'd31)};
                            r_state <= c_WAIT_B2;
                        end
                    end
                    c_WAIT_B2: begin
                        r_tuple <= {r_src, r_dst, w_ports_b2, r_proto};
                        r_valid <= 1'b1;
                        r_state <= s_axis_tlast ? c_WAIT_B0 : c_DRAIN;
                    end
                    default: begin
                        if (s_axis_tlast) begin
                            r_state <= c_WAIT_B0;
                        end
                    end
                endcase
            end
        end
    end

    assign five_tuple_data = r_tuple;
    assign data_valid      = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_five_tuple_extract.sv
// tb_five_tuple_extract: directed and random packets checked against a
// byte-array model of the five-tuple rules.
`default_nettype none

module tb_five_tuple_extract;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] tdata = '0;
    logic [31:0]  tkeep = '1;
    logic [127:0] tuser = '0;
    logic         tvalid = 1'b0;
    logic         tready = 1'b0;
    logic         tlast = 1'b0;
    logic [103:0] tuple_o;
    logic         valid_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]   pkt [0:127];
    logic [103:0] exp_hold = '0;

    five_tuple_extract dut (
        .axi_aclk        (clk),
        .axi_aresetn     (rst_n),
        .s_axis_tdata    (tdata),
        .s_axis_tkeep    (tkeep),
        .s_axis_tuser    (tuser),
        .s_axis_tvalid   (tvalid),
        .s_axis_tready   (tready),
        .s_axis_tlast    (tlast),
        .five_tuple_data (tuple_o),
        .data_valid      (valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic build(input logic [15:0] eth, input logic [3:0] ver, input logic [3:0] ihl,
                         input logic [7:0] proto, input logic [12:0] frag,
                         input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] sp, input logic [15:0] dp);
        int p;
        for (int k = 0; k < 128; k++) pkt[k] = 8'($urandom);
        {pkt[12], pkt[13]} = eth;
        pkt[14] = {ver, ihl};
        pkt[20] = {pkt[20][7:5], frag[12:8]};
        pkt[21] = frag[7:0];
        pkt[23] = proto;
        {pkt[26], pkt[27], pkt[28], pkt[29]} = src;
        {pkt[30], pkt[31], pkt[32], pkt[33]} = dst;
        p = 14 + 4 * int'(ihl);
        {pkt[p], pkt[p+1], pkt[p+2], pkt[p+3]} = {sp, dp};
    endtask

    // Strobe expected after beat 'need' when the packet has more than 'need' beats.
    task automatic model(input int nb, output bit ok, output int need, output logic [103:0] tup);
        int  ihl;
        int  p;
        bit  l4;
        ok = 0; need = 1; tup = '0;
        ihl = int'(pkt[14][3:0]);
        if ({pkt[12], pkt[13]} != 16'h0800 || pkt[14][7:4] != 4'd4 || ihl < 5) return;
        p    = 14 + 4 * ihl;
        l4   = (pkt[23] == 8'd6 || pkt[23] == 8'd17) && ({pkt[20][4:0], pkt[21]} == 13'd0);
        need = l4 ? (p + 3) / 32 : 1;
        ok   = (nb > need);
        tup  = {pkt[26], pkt[27], pkt[28], pkt[29], pkt[30], pkt[31], pkt[32], pkt[33],
                l4 ? {pkt[p], pkt[p+1], pkt[p+2], pkt[p+3]} : 32'h0, pkt[23]};
    endtask

    // mode 0: no stalls, 1: tready toggles each cycle, 2: random idles/bubbles
    task automatic send_pkt(input int nb, input int mode);
        bit          ok;
        int          need;
        logic [103:0] tup;
        int          bi;
        logic        tog;
        logic        v;
        logic        r;
        logic        acc;
        logic        ev;
        bi = 0; tog = 1'b1;
        model(nb, ok, need, tup);
        while (bi < nb) begin
            case (mode)
                1:       begin v = 1'b1; r = tog; tog = ~tog; end
                2:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
                default: begin v = 1'b1; r = 1'b1; end
            endcase
            for (int k = 0; k < 32; k++) tdata[8*k +: 8] = pkt[32*bi + k];
            tvalid = v;
            tready = r;
            tlast  = v ? (bi == nb - 1) : 1'($urandom);
            @(posedge clk); #1;
            acc = v && r;
            ev  = acc && ok && (bi == need);
            if (ev) exp_hold = tup;
            chk("data_valid", {103'd0, valid_o}, {103'd0, ev});
            chk("five_tuple_data", tuple_o, exp_hold);
            if (acc) bi++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_valid", {103'd0, valid_o}, 104'd0);
            chk("idle_tuple", tuple_o, exp_hold);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {103'd0, valid_o}, 104'd0);
        chk("reset_tuple", tuple_o, 104'd0);
        rst_n = 1'b1;
        tready = 1'b1;
        idle(2);

        build(16'h0800, 4'd4, 4'd5, 8'd6, 13'd0, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050);
        send_pkt(2, 0);
        chk("tcp_tuple_literal", tuple_o, 104'h0A000001_0A000002_1234_0050_06);

        build(16'h0800, 4'd4, 4'd12, 8'd17, 13'd0, 32'hC0A80101, 32'hC0A80102, 16'h0035, 16'hC001);
        send_pkt(3, 0);
        chk("udp_ihl12_tuple", tuple_o, 104'hC0A80101_C0A80102_0035_C001_11);

        build(16'h0806, 4'd4, 4'd5, 8'd6, 13'd0, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222);
        send_pkt(2, 0);
        build(16'h0800, 4'd4, 4'd5, 8'd1, 13'd0, 32'h0B000001, 32'h0B000002, 16'h3333, 16'h4444);
        send_pkt(2, 0);
        chk("icmp_tuple", tuple_o, 104'h0B000001_0B000002_0000_0000_01);

        build(16'h0800, 4'd4, 4'd5, 8'd6, 13'h00B9, 32'h0C000001, 32'h0C000002, 16'h5555, 16'h6666);
        send_pkt(2, 0);
        build(16'h0800, 4'd4, 4'd15, 8'd6, 13'd0, 32'h0D000001, 32'h0D000002, 16'h7777, 16'h8888);
        send_pkt(2, 0);
        idle(2);

        build(16'h0800, 4'd4, 4'd12, 8'd17, 13'd0, 32'hC0A80101, 32'hC0A80102, 16'h0035, 16'hC001);
        send_pkt(3, 1);
        chk("udp_stall_tuple", tuple_o, 104'hC0A80101_C0A80102_0035_C001_11);

        // Reset asserted while beat1 of a TCP packet is on the bus.
        build(16'h0800, 4'd4, 4'd5, 8'd6, 13'd0, 32'h0E000001, 32'h0E000002, 16'h9999, 16'hAAAA);
        send_pkt(1, 0);
        for (int k = 0; k < 32; k++) tdata[8*k +: 8] = pkt[32 + k];
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_hold = '0;
        chk("async_rst_valid", {103'd0, valid_o}, 104'd0);
        chk("async_rst_tuple", tuple_o, 104'd0);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
        chk("rst_hold_tuple", tuple_o, 104'd0);
        rst_n = 1'b1;
        idle(2);
        build(16'h0800, 4'd4, 4'd5, 8'd6, 13'd0, 32'h0F000001, 32'h0F000002, 16'hBBBB, 16'hCCCC);
        send_pkt(2, 0);
        chk("post_rst_tuple", tuple_o, 104'h0F000001_0F000002_BBBB_CCCC_06);

        // Random packets, back-to-back or with random stalls.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] eth;
            logic [3:0]  ver;
            logic [3:0]  ihl;
            logic [7:0]  proto;
            logic [12:0] frag;
            int          sel;
            eth   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0800;
            ver   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd4;
            ihl   = 4'($urandom_range(3, 15));
            sel   = $urandom_range(0, 3);
            proto = (sel == 0) ? 8'd6 : (sel == 1) ? 8'd17 : (sel == 2) ? 8'd1 : 8'($urandom);
            frag  = ($urandom_range(0, 4) == 0) ? 13'($urandom) : 13'd0;
            build(eth, ver, ihl, proto, frag, $urandom, $urandom, 16'($urandom), 16'($urandom));
            send_pkt($urandom_range(1, 4), $urandom_range(0, 2));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
